// File: rtl/gost89_pkg.sv
// Shared types, sizes and key-schedule helpers for the GOST 28147-89 MAC stream.
package gost89_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_IN,
        DONE
    } state_t;

    localparam int GOST89_ROUNDS  = 16;
    localparam int GOST89_BLOCK_W = 64;

    // Round r uses K[r mod 8], so the 16 rounds walk K1..K8 twice.
    function automatic logic [2:0] key_index(input logic [3:0] round);
        return round[2:0];
    endfunction

    // K1 sits in the most significant word of the key bus.
    function automatic logic [31:0] key_word(input logic [255:0] key, input logic [2:0] idx);
        return key[(7 - int'(idx)) * 32 +: 32];
    endfunction

endpackage

// File: rtl/gost89_round.sv
// One combinational GOST 28147-89 round: add key, S-box substitute, rotate by 11, mix, swap.
module gost89_round
    import gost89_pkg::*;
(
    input  logic [511:0] sbox,
    input  logic [31:0]  round_key,
    input  logic [31:0]  n1,
    input  logic [31:0]  n2,
    output logic [31:0]  n1_next,
    output logic [31:0]  n2_next
);

    localparam int HALF_W = GOST89_BLOCK_W / 2;

    logic [HALF_W-1:0] sum;
    logic [HALF_W-1:0] subst;
    logic [HALF_W-1:0] rotated;

    assign sum = n1 + round_key;

    // Nibble i is looked up in row i; entry j of a row occupies bits [4j+3:4j].
    always_comb begin
        subst = '0;
        for (int i = 0; i < 8; i++) begin
            subst[4*i +: 4] = sbox[64*i + 4*int'(sum[4*i +: 4]) +: 4];
        end
    end

    assign rotated = {subst[20:0], subst[31:21]};
    assign n1_next = n2 ^ rotated;
    assign n2_next = n1;

endmodule

// File: rtl/gost89_mac_stream.sv
// Streaming GOST 28147-89 MAC engine: 16 rounds per block, CBC-style chaining between blocks.
// Optional tail padding and auto zero-block for single-block messages: define GOST89_MAC_PAD_EN.
module gost89_mac_stream
    import gost89_pkg::*;
#(
    parameter int MAC_WIDTH = 32,
    parameter int MULTI_KEY = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [511:0]         sbox,
    input  logic [255:0]         key,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_data,
    input  logic                 in_last,
`ifdef GOST89_MAC_PAD_EN
    input  logic [2:0]           in_nbytes,
`endif
    output logic                 mac_valid,
    input  logic                 mac_ready,
    output logic [MAC_WIDTH-1:0] mac,
    output logic                 busy
);

    state_t       state;
    state_t       state_next;
    logic [3:0]   round_cnt;
    logic [31:0]  n1;
    logic [31:0]  n2;
    logic [31:0]  n1_round;
    logic [31:0]  n2_round;
    logic         last_flag;
    logic         accept;
    logic         last_round;
    logic         auto_blk;
    logic [63:0]  blk_data;
    logic [63:0]  result;
    logic [255:0] key_use;
    logic [511:0] sbox_use;

    assign in_ready   = reset_n && ((state == IDLE) || ((state == WAIT_IN) && !auto_blk));
    assign accept     = in_valid && in_ready;
    assign last_round = (round_cnt == 4'(GOST89_ROUNDS - 1));

    generate
        if (MULTI_KEY != 0) begin : g_latched
            logic [255:0] key_q;
            logic [511:0] sbox_q;

            // Key material is frozen for the whole message at the first accepted block.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    key_q  <= '0;
                    sbox_q <= '0;
                end else if ((state == IDLE) && accept) begin
                    key_q  <= key;
                    sbox_q <= sbox;
                end
            end

            assign key_use  = key_q;
            assign sbox_use = sbox_q;
        end else begin : g_live
            assign key_use  = key;
            assign sbox_use = sbox;
        end
    endgenerate

`ifdef GOST89_MAC_PAD_EN
    logic pad_pending;

    assign auto_blk = pad_pending;

    // A partial final block keeps only its top in_nbytes bytes.
    always_comb begin
        blk_data = in_data;
        if (in_last && (in_nbytes != 3'd0)) begin
            blk_data = in_data & (64'hFFFF_FFFF_FFFF_FFFF << (64 - 8 * int'(in_nbytes)));
        end
    end
`else
    assign auto_blk = 1'b0;
    assign blk_data = in_data;
`endif

    gost89_round u_round (
        .sbox      (sbox_use),
        .round_key (key_word(key_use, key_index(round_cnt))),
        .n1        (n1),
        .n2        (n2),
        .n1_next   (n1_round),
        .n2_next   (n2_round)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_round) state_next = (last_flag && !auto_blk) ? DONE : WAIT_IN;
            WAIT_IN: if (accept || auto_blk) state_next = RUN;
            DONE:    if (mac_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The auto zero block chains as r ^ 0, so only the pending flag changes in WAIT_IN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            n1        <= '0;
            n2        <= '0;
            round_cnt <= '0;
            last_flag <= 1'b0;
`ifdef GOST89_MAC_PAD_EN
            pad_pending <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        n1        <= blk_data[63:32];
                        n2        <= blk_data[31:0];
                        round_cnt <= '0;
                        last_flag <= in_last;
`ifdef GOST89_MAC_PAD_EN
                        pad_pending <= in_last;
`endif
                    end
                end
                RUN: begin
                    n1        <= n1_round;
                    n2        <= n2_round;
                    round_cnt <= round_cnt + 4'd1;
                end
                WAIT_IN: begin
`ifdef GOST89_MAC_PAD_EN
                    if (auto_blk) begin
                        pad_pending <= 1'b0;
                        round_cnt   <= '0;
                    end else
`endif
                    if (accept) begin
                        n1        <= n1 ^ blk_data[63:32];
                        n2        <= n2 ^ blk_data[31:0];
                        round_cnt <= '0;
                        last_flag <= in_last;
                    end
                end
                DONE: begin
                    if (mac_ready) begin
                        n1        <= '0;
                        n2        <= '0;
                        round_cnt <= '0;
                        last_flag <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = {n2, n1};
    assign mac_valid = (state == DONE);
    assign mac       = (state == DONE) ? result[GOST89_BLOCK_W-1 -: MAC_WIDTH] : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gost89_mac_stream.sv
// Self-checking bench for gost89_mac_stream: table of messages plus reset, hold and key-latch sequences.
// Also covers the padded build when GOST89_MAC_PAD_EN is defined.
module tb_gost89_mac_stream;

`ifdef GOST89_MAC_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    typedef struct {
        logic [2:0][63:0] blk;
        int               nblk;
        logic [2:0]       nbytes;
        logic [255:0]     key;
        logic [511:0]     sbox;
        bit               hold_ready;
        logic [63:0]      exp;
    } vec_t;

    logic         clk;
    logic         reset_n;
    logic [511:0] sbox;
    logic [255:0] key;
    logic         in_valid;
    logic [63:0]  in_data;
    logic         in_last;
    logic         mac_ready;
`ifdef GOST89_MAC_PAD_EN
    logic [2:0]   in_nbytes;
`endif
    logic         in_ready, in_ready8, in_ready64;
    logic         mac_valid, mac_valid8, mac_valid64;
    logic         busy, busy8, busy64;
    logic [31:0]  mac32;
    logic [7:0]   mac8;
    logic [63:0]  mac64;

    int           n_checks;
    int           n_pass;
    int           gap;
    int           lat;
    bit           swap_en;
    logic [255:0] swap_key;
    vec_t         vecs [5];

    gost89_mac_stream #(.MAC_WIDTH(32), .MULTI_KEY(0)) dut (
        .clk(clk), .reset_n(reset_n), .sbox(sbox), .key(key),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
`ifdef GOST89_MAC_PAD_EN
        .in_nbytes(in_nbytes),
`endif
        .mac_valid(mac_valid), .mac_ready(mac_ready), .mac(mac32), .busy(busy)
    );

    gost89_mac_stream #(.MAC_WIDTH(8), .MULTI_KEY(0)) dut8 (
        .clk(clk), .reset_n(reset_n), .sbox(sbox), .key(key),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data), .in_last(in_last),
`ifdef GOST89_MAC_PAD_EN
        .in_nbytes(in_nbytes),
`endif
        .mac_valid(mac_valid8), .mac_ready(mac_ready), .mac(mac8), .busy(busy8)
    );

    gost89_mac_stream #(.MAC_WIDTH(64), .MULTI_KEY(1)) dut64 (
        .clk(clk), .reset_n(reset_n), .sbox(sbox), .key(key),
        .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data), .in_last(in_last),
`ifdef GOST89_MAC_PAD_EN
        .in_nbytes(in_nbytes),
`endif
        .mac_valid(mac_valid64), .mac_ready(mac_ready), .mac(mac64), .busy(busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference cipher: returns {n1, n2} after 16 rounds.
    function automatic logic [63:0] model_enc(input logic [63:0] blk, input logic [255:0] k,
                                              input logic [511:0] sb);
        logic [31:0] a, b, kw, s, sub, f;
        logic [63:0] row;
        a = blk[63:32];
        b = blk[31:0];
        for (int r = 0; r < 16; r++) begin
            kw  = 32'(k >> (224 - 32 * (r % 8)));
            s   = a + kw;
            sub = '0;
            for (int i = 0; i < 8; i++) begin
                row = 64'(sb >> (64 * i));
                sub = sub | (32'((row >> (4 * ((s >> (4 * i)) & 32'hF))) & 64'hF) << (4 * i));
            end
            f = (sub << 11) | (sub >> 21);
            {a, b} = {b ^ f, a};
        end
        return {a, b};
    endfunction

    // Reference MAC: returns {r2, r1}.
    function automatic logic [63:0] model_mac(input vec_t v);
        logic [63:0] st, d;
        st = '0;
        for (int j = 0; j < v.nblk; j++) begin
            d = v.blk[j];
            if (PAD && (j == v.nblk - 1) && (v.nbytes != 3'd0))
                d = d & ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * v.nbytes));
            st = model_enc(st ^ d, v.key, v.sbox);
        end
        if (PAD && (v.nblk == 1))
            st = model_enc(st, v.key, v.sbox);
        return {st[31:0], st[63:32]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Feeds every block with in_valid held high, then waits for the MAC; leaves DUT in DONE.
    task automatic applyStimulus(input vec_t v);
        int wc;
        key       = v.key;
        sbox      = v.sbox;
        mac_ready = v.hold_ready;
        gap       = 0;
        lat       = 0;
        wc        = 0;
        for (int j = 0; j < v.nblk; j++) begin
            in_valid = 1'b1;
            in_data  = v.blk[j];
            in_last  = (j == v.nblk - 1);
`ifdef GOST89_MAC_PAD_EN
            in_nbytes = v.nbytes;
`endif
            while (!in_ready && wc < 100) begin
                @(negedge clk);
                wc++;
            end
            if (!in_ready) begin
                checkOutput("accept_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            if (j > 0) gap = wc;
            @(negedge clk);
            wc = 1;
            if (j == 0) checkOutput("ready_drop", {in_ready, busy}, 2'b01);
            if (j == 0 && swap_en) key = swap_key;
        end
        in_data = ~in_data;
        lat = wc;
        while (!mac_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!mac_valid) checkOutput("mac_timeout", 64'd0, 64'd1);
    endtask

    task automatic finishMessage();
        mac_ready = 1'b1;
        @(negedge clk);
        mac_ready = 1'b0;
        checkOutput("idle_after_ack",
                    {mac_valid, busy, in_ready, mac_valid8, busy8, in_ready8,
                     mac_valid64, busy64, in_ready64}, 9'b001_001_001);
    endtask

    initial begin
        logic [511:0] sb_id, sb_p;
        logic [255:0] key_a, key_b;
        logic [63:0]  exp_swap;
        vec_t         vtmp;

        n_checks  = 0;
        n_pass    = 0;
        swap_en   = 1'b0;
        swap_key  = '0;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
        in_last   = 1'b1;
        mac_ready = 1'b1;
`ifdef GOST89_MAC_PAD_EN
        in_nbytes = 3'd0;
`endif

        sb_id = {8{64'hFEDC_BA98_7654_3210}};
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 16; j++)
                sb_p[64*i + 4*j +: 4] = 4'((7 * j + 3 * i + 5) % 16);
        key_a = 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        key_b = 256'h13579BDF_2468ACE0_DEADBEEF_CAFEF00D_00000001_80000000_55555555_AAAAAAAA;
        key   = '0;
        sbox  = sb_id;

        vecs[0] = '{blk: {64'h0, 64'h0, 64'h0123_4567_89AB_CDEF}, nblk: 1, nbytes: 3'd0,
                    key: '0, sbox: sb_id, hold_ready: 1'b0, exp: '0};
        vecs[1] = '{blk: {64'h1111_2222_3333_4444, 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF},
                    nblk: 3, nbytes: 3'd0, key: '0, sbox: sb_id, hold_ready: 1'b0, exp: '0};
        vecs[2] = '{blk: {64'h0, 64'h0F0F_0F0F_F0F0_F0F0, 64'hA5A5_A5A5_5A5A_5A5A}, nblk: 2,
                    nbytes: 3'd0, key: key_a, sbox: sb_p, hold_ready: 1'b1, exp: '0};
        vecs[3] = '{blk: {64'h0, 64'h0, 64'h8899_AABB_CCDD_EEFF}, nblk: 1, nbytes: 3'd0,
                    key: key_a, sbox: sb_p, hold_ready: 1'b0, exp: '0};
        vecs[4] = '{blk: {64'h0, 64'h0, 64'h0123_4567_89AB_CDEF}, nblk: 1, nbytes: 3'd3,
                    key: key_a, sbox: sb_id, hold_ready: 1'b0, exp: '0};
        for (int i = 0; i < 5; i++) vecs[i].exp = model_mac(vecs[i]);

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {in_ready, mac_valid, busy, mac32}, 64'd0);
        checkOutput("reset_mac64", mac64, 64'd0);
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        mac_ready = 1'b0;
        #1;
        checkOutput("ready_after_reset", in_ready, 1'b1);
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("mac32_v%0d", i), mac32, vecs[i].exp[63:32]);
            checkOutput($sformatf("mac8_v%0d", i), mac8, vecs[i].exp[63:56]);
            checkOutput($sformatf("mac64_v%0d", i), mac64, vecs[i].exp);
            checkOutput($sformatf("valid_all_v%0d", i), {mac_valid, mac_valid8, mac_valid64}, 3'b111);
            checkOutput($sformatf("latency_v%0d", i), lat, (PAD && vecs[i].nblk == 1) ? 34 : 17);
            if (vecs[i].nblk > 1) checkOutput($sformatf("gap_v%0d", i), gap, 17);
            finishMessage();
        end

        applyStimulus(vecs[0]);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_c%0d", c), {mac32, in_ready, busy, mac_valid},
                        {vecs[0].exp[63:32], 3'b011});
        end
        finishMessage();

        key      = '0;
        sbox     = sb_id;
        in_valid = 1'b1;
        in_data  = vecs[1].blk[0];
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midrun_reset", {in_ready, mac_valid, busy, mac32}, 64'd0);
        checkOutput("midrun_reset_mac64", {busy64, mac64}, 65'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("midrun_ready_after", in_ready, 1'b1);
        @(negedge clk);
        applyStimulus(vecs[0]);
        checkOutput("post_reset_mac32", mac32, vecs[0].exp[63:32]);
        checkOutput("post_reset_mac64", mac64, vecs[0].exp);
        finishMessage();

        vtmp     = vecs[3];
        vtmp.key = key_b;
        exp_swap = model_mac(vtmp);
        swap_en  = 1'b1;
        swap_key = key_b;
        applyStimulus(vecs[3]);
        checkOutput("live_key_mac32", mac32, exp_swap[63:32]);
        checkOutput("latched_key_mac64", mac64, vecs[3].exp);
        swap_en = 1'b0;
        finishMessage();

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
